niosqsys_pio_edge: RTL and testbench

- Parametrised bidirectional PIO Avalon-MM slave for the Nios Qsys system; successor to the fixed 32-bit input-only PIO.
- Adds an input synchroniser, output data and direction registers, per-bit edge capture, interrupt mask and a level IRQ to the CPU.
- Sits between the Nios data master interconnect and board-level GPIO pins.

---
 rtl/niosqsys_pio_edge.sv | 142 ++++++++++++++
 tb/tb_niosqsys_pio_edge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/niosqsys_pio_edge.sv
// Parametrised bidirectional PIO Avalon-MM slave with input synchroniser, edge capture and IRQ.
// Optional build macro NIOSQSYS_PIO_BITCLR_EN: per-bit edgecapture clear instead of clear-all.
module niosqsys_pio_edge #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter logic [31:0] RESET_OUT   = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam logic [WIDTH-1:0] OUT_RST = WIDTH'(RESET_OUT);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_oe;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic             r_irq;
    logic [31:0]      r_rd;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_cap_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic [31:0]      w_rd_nxt;
    logic             w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;
    assign w_sync_q       = r_sync[SYNC_STAGES-1];

    // Input synchroniser chain plus one-cycle delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_q;
        end
    end

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_sync_q & ~r_prev;
            1:       w_edge = ~w_sync_q & r_prev;
            default: w_edge = w_sync_q ^ r_prev;
        endcase
    end

    // Edge capture: a fresh edge always wins over a software clear of the same bit
    always_comb begin
        w_cap_nxt = r_cap | w_edge;
        if (w_wr && (address == ADDR_EDGE)) begin
`ifdef NIOSQSYS_PIO_BITCLR_EN
            w_cap_nxt = (r_cap & ~w_wdata) | w_edge;
`else
            w_cap_nxt = w_edge;
`endif
        end
    end

    always_comb begin
        w_out_nxt = r_out;
        if (w_wr) begin
            case (address)
                ADDR_DATA:   w_out_nxt = w_wdata;
                ADDR_OUTSET: w_out_nxt = r_out | w_wdata;
                ADDR_OUTCLR: w_out_nxt = r_out & ~w_wdata;
                default:     w_out_nxt = r_out;
            endcase
        end
    end

    always_comb begin
        w_rd_nxt = 32'h0;
        case (address)
            ADDR_DATA: w_rd_nxt = 32'(w_sync_q);
            ADDR_DIR:  w_rd_nxt = 32'(r_oe);
            ADDR_MASK: w_rd_nxt = 32'(r_mask);
            ADDR_EDGE: w_rd_nxt = 32'(r_cap);
            default:   w_rd_nxt = 32'h0;
        endcase
    end

    // Register file, read data and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out  <= OUT_RST;
            r_oe   <= '0;
            r_mask <= '0;
            r_cap  <= '0;
            r_irq  <= 1'b0;
            r_rd   <= 32'h0;
        end else begin
            r_out <= w_out_nxt;
            r_cap <= w_cap_nxt;
            r_irq <= |(r_cap & r_mask);
            r_rd  <= w_rd_nxt;
            if (w_wr && (address == ADDR_DIR)) begin
                r_oe <= w_wdata;
            end
            if (w_wr && (address == ADDR_MASK)) begin
                r_mask <= w_wdata;
            end
        end
    end

    assign readdata = r_rd;
    assign out_port = r_out;
    assign out_oe   = r_oe;
    assign irq      = r_irq;

endmodule

// File: tb/tb_niosqsys_pio_edge.sv
// Directed bench for niosqsys_pio_edge: WIDTH=8, 2 sync stages, rising-edge capture, RESET_OUT=0x5A.
module tb_niosqsys_pio_edge;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic [W-1:0] out_oe;
    logic         irq;

    int n_vec;
    int n_err;

    niosqsys_pio_edge #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .EDGE_TYPE  (0),
        .RESET_OUT  (32'h5A)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .out_oe    (out_oe),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         is_wr;
        logic [2:0]   addr;
        logic [31:0]  data;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_oe;
        logic [31:0]  exp_rd;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
        d          = readdata;
    endtask

    logic [31:0] rd;

    initial begin
        n_vec = 0;
        n_err = 0;

        //                 wr    addr  data           out    oe     rd
        vt[0]  = '{1'b1, 3'd0, 32'h0000003C, 8'h3C, 8'h00, 32'h0};
        vt[1]  = '{1'b1, 3'd4, 32'h00000003, 8'h3F, 8'h00, 32'h0};
        vt[2]  = '{1'b1, 3'd5, 32'h0000000C, 8'h33, 8'h00, 32'h0};
        vt[3]  = '{1'b1, 3'd1, 32'h000000FF, 8'h33, 8'hFF, 32'h0};
        vt[4]  = '{1'b0, 3'd1, 32'h0,        8'h33, 8'hFF, 32'h000000FF};
        vt[5]  = '{1'b0, 3'd0, 32'h0,        8'h33, 8'hFF, 32'h000000A5};
        vt[6]  = '{1'b0, 3'd4, 32'h0,        8'h33, 8'hFF, 32'h0};
        vt[7]  = '{1'b0, 3'd5, 32'h0,        8'h33, 8'hFF, 32'h0};
        vt[8]  = '{1'b1, 3'd6, 32'h000000FF, 8'h33, 8'hFF, 32'h0};
        vt[9]  = '{1'b1, 3'd7, 32'h00000000, 8'h33, 8'hFF, 32'h0};
        vt[10] = '{1'b0, 3'd6, 32'h0,        8'h33, 8'hFF, 32'h0};
        vt[11] = '{1'b0, 3'd7, 32'h0,        8'h33, 8'hFF, 32'h0};
        vt[12] = '{1'b1, 3'd2, 32'h00000081, 8'h33, 8'hFF, 32'h0};
        vt[13] = '{1'b0, 3'd2, 32'h0,        8'h33, 8'hFF, 32'h00000081};
        vt[14] = '{1'b1, 3'd0, 32'hFFFFFF12, 8'h12, 8'hFF, 32'h0};

        // Reset and synchronised input read
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hA5;
        repeat (2) tick();
        check("rst_readdata", readdata, 32'h0);
        check("rst_out_port", 32'(out_port), 32'h5A);
        check("rst_out_oe", 32'(out_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        repeat (4) tick();
        bus_read(3'd0, rd);
        check("sync_read_A5", rd, 32'h000000A5);
        check("post_rst_irq", 32'(irq), 32'h0);

        // Register map table
        for (int i = 0; i < 15; i++) begin
            if (vt[i].is_wr) begin
                bus_write(vt[i].addr, vt[i].data);
                check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vt[i].exp_out));
                check($sformatf("vec%0d_oe", i), 32'(out_oe), 32'(vt[i].exp_oe));
            end else begin
                bus_read(vt[i].addr, rd);
                check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
            end
        end

        // Rising capture on bit 0 with exact latency
        bus_write(3'd2, 32'h01);
        in_port = 8'hA4;
        repeat (5) tick();
        bus_write(3'd3, 32'hFF);
        tick();
        in_port = 8'hA5;
        repeat (3) tick();
        check("rise_cap_early", readdata, 32'h0);
        check("rise_irq_early", 32'(irq), 32'h0);
        tick();
        check("rise_cap", readdata, 32'h01);
        check("rise_irq", 32'(irq), 32'h1);

        // Falling edge on bit 2 is ignored
        in_port = 8'hA1;
        repeat (5) tick();
        check("fall_ignored", readdata, 32'h01);

        // Masked bit still captures; unmasking raises irq next cycle
        bus_write(3'd2, 32'h00);
        bus_write(3'd3, 32'hFF);
        tick();
        in_port = 8'hA5;
        repeat (5) tick();
        check("mask_cap", readdata, 32'h04);
        check("mask_irq_low", 32'(irq), 32'h0);
        bus_write(3'd2, 32'h04);
        check("unmask_irq_same", 32'(irq), 32'h0);
        tick();
        check("unmask_irq", 32'(irq), 32'h1);

        // Clear behaviour
        address = 3'd3;
        in_port = 8'hA4;
        repeat (5) tick();
        in_port = 8'hA5;
        repeat (5) tick();
        check("clr_pre", readdata, 32'h05);
        bus_write(3'd3, 32'h01);
        tick();
`ifdef NIOSQSYS_PIO_BITCLR_EN
        check("clr_bit", readdata, 32'h04);
`else
        check("clr_all", readdata, 32'h00);
`endif
        in_port = 8'hA4;
        repeat (5) tick();
        in_port = 8'hA5;
        tick();
        tick();
        bus_write(3'd3, 32'h01);
        tick();
`ifdef NIOSQSYS_PIO_BITCLR_EN
        check("clr_edge_wins", readdata, 32'h05);
`else
        check("clr_edge_wins", readdata, 32'h01);
`endif

        // Asynchronous reset mid-operation
        bus_write(3'd2, 32'hFF);
        in_port = 8'hAF;
        repeat (5) tick();
        check("pre_rst_irq", 32'(irq), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_irq", 32'(irq), 32'h0);
        check("async_out", 32'(out_port), 32'h5A);
        check("async_oe", 32'(out_oe), 32'h0);
        check("async_rd", readdata, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus_read(3'd3, rd);
        check("rst_cap", rd, 32'h0);
        bus_read(3'd2, rd);
        check("rst_mask", rd, 32'h0);

        // Synchroniser latency at the data address
        repeat (3) tick();
        address = 3'd0;
        tick();
        check("sync_old", readdata, 32'hAF);
        in_port = 8'h3C;
        tick();
        tick();
        check("sync_lat_hold", readdata, 32'hAF);
        tick();
        check("sync_lat_new", readdata, 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
